alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester controller that shares the single `ALU` (add/sub datapath) between two bus masters, such as the instruction sequencer and the address generator. It arbitrates round-robin, latches the winner's operands and mode, drives the ALU's `cs`/`ready` handshake, captures the result from the ALU bus, and returns it with a one-cycle `done` pulse. Watchdog counters turn a hung ALU into an error response instead of a deadlock.

## Interface
Parameters:
- `WIDTH`, 16: operand and result width.
- `ACK_WAIT`, 4: maximum cycles from `alu_cs` to `alu_ready` falling.
- `TIMEOUT`, 64: maximum cycles with `alu_ready` low before abort.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req0`, `req1`, in, 1: operation requests; held high until the matching `done`.
- `a0`, `b0`, `a1`, `b1`, in, WIDTH: requester operands.
- `mode0`, `mode1`, in, 1: 0 = add, 1 = subtract (a−b).
- `gnt0`, `gnt1`, out, 1: requester owns the ALU (ISSUE through RESP).
- `done0`, `done1`, out, 1: one-cycle completion pulse.
- `err`, out, 1: qualifies `done`; 1 = timeout abort.
- `result`, out, WIDTH: valid in the `done` cycle; held afterwards.
- `alu_cs`, out, 1: one-cycle start strobe to the ALU.
- `alu_mode`, out, 1: registered mode to the ALU.
- `alu_a`, `alu_b`, out, WIDTH: registered operands to the ALU.
- `alu_bus`, in, WIDTH: ALU result bus.
- `alu_ready`, in, 1: ALU idle (1) / busy (0).

## Operation
FSM states:
- **IDLE**
  - Sample `req0`/`req1` only when `alu_ready`=1.
  - Winner is chosen by the `last` pointer: the requester not served last wins on a tie; a single request wins outright.
  - Latch the winner's operands into `alu_a`/`alu_b` and its mode into `alu_mode`; record the owner.
  - Go to ISSUE.
- **ISSUE**
  - `alu_cs`=1 for exactly this cycle; clear the counter.
  - Go to WAIT_BUSY.
- **WAIT_BUSY**
  - `alu_ready`=0 → WAIT_DONE, counter cleared.
  - Counter reaches `ACK_WAIT` → RESP with `err`=1.
- **WAIT_DONE**
  - `alu_ready`=1 → capture `alu_bus` into `result`, go to RESP.
  - Counter reaches `TIMEOUT` → RESP with `err`=1 and `result`=0.
- **RESP**
  - Pulse the owner's `done`.
  - Drop `gnt`, set `last` to the owner, go to IDLE.

Rules:
- `gnt` for the owner is high from ISSUE through RESP inclusive.
- Operands and mode are frozen for the whole transaction; requester inputs may change after `gnt`.
- `req` deasserted mid-transaction is ignored: the operation completes and `done` still pulses.
- A requester holding `req` after `done` is rearbitrated normally in IDLE. A sole requester may be served back-to-back; fairness only applies on ties.
- Arithmetic is performed by the ALU; this block never modifies `alu_bus`. Overflow is not flagged.
- Counter width is `$clog2(TIMEOUT+1)`.

## Timing
Reset (async assert, sync release):
- state=IDLE, `last`=1 (so `req0` wins the first tie).
- All outputs 0: `gnt*`, `done*`, `err`, `alu_cs`, `alu_mode`, `alu_a`, `alu_b`, `result`.

Reset mid-transaction: abort immediately; no `done` is produced. The ALU recovers through its own idle path.

Latency:
- `req` sampled at edge N: `gnt` and operands valid after N; `alu_cs` high in cycle N+1.
- Ready-fall wait: d cycles, with 1 ≤ d ≤ `ACK_WAIT`.
- Busy period: k cycles.
- `done` pulses 3+d+k cycles after edge N.
- Next arbitration occurs in the cycle after `done`. Minimum back-to-back spacing is 4+d+k cycles.

Boundary conditions:
- `alu_ready`=0 while in IDLE: no grant; requests wait.
- Both requests asserted in the same cycle as RESP: arbitration happens in IDLE with the updated `last`.
- `alu_ready` glitching high during WAIT_BUSY is ignored; only the falling edge is detected.

## Structure
- Shared package `alu_ctrl_pkg`:
  - State encoding: IDLE=0, ISSUE=1, WAIT_BUSY=2, WAIT_DONE=3, RESP=4.
  - `ALU_ADD`=0, `ALU_SUB`=1.
  - Default `WIDTH`.
- Sub-module `rr_arb2`: combinational 2-way round-robin picker with inputs `req[1:0]`, `last` and outputs `pick`, `valid`.
- The FSM, counter, and operand/result registers live in `alu_arbiter`.

## Test plan
1. **Single add:** `req0` with a0=0x0003, b0=0x0004, mode0=0; ALU model drops ready 1 cycle after `cs` and is busy 2 cycles. Required: `alu_cs` is one pulse; `done0` arrives 6 cycles after the sampling edge, with `result`=0x0007 and `err`=0.
2. **Tie fairness:** `req0` and `req1` held high, a1=0x0010, b1=0x0001, mode1=1. Required: grants alternate 0,1,0,1; the requester-1 result is 0x000F; no requester is served twice in a row.
3. **ACK timeout:** `alu_ready` stuck at 1 after `cs`. Required: `done` with `err`=1 exactly `ACK_WAIT` cycles into WAIT_BUSY, then return to IDLE.
4. **Busy timeout:** `alu_ready` stuck at 0. Required: `done` with `err`=1 and `result`=0x0000 after `TIMEOUT` cycles; the next request is still served.
5. **Operand freeze:** change a0 to 0xFFFF one cycle after `gnt0`. Required: `alu_a` keeps its original value and `result` reflects the original operands.
6. **Reset mid-operation:** assert `rst_n`=0 in WAIT_DONE. Required: all outputs are 0 immediately, no `done` pulse, and `req0` wins the first tie after release.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared state encoding, ALU mode codes and default width for the ALU arbiter
package alu_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;
  localparam int DEF_WIDTH = 16;
endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker; the requester not served last wins a tie
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       pick,
  output logic       valid
);
  always_comb begin
    valid = |req;
    pick = &req ? ~last : req[1];
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one add/sub ALU between two requesters with round-robin grant and watchdog aborts
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int ACK_WAIT = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             mode0,
  input  logic             mode1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             alu_cs,
  output logic             alu_mode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_bus,
  input  logic             alu_ready
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic owner, last, err_q, pick, valid, start, ack_to, busy_to;
  rr_arb2 u_arb (.req({req1, req0}), .last(last), .pick(pick), .valid(valid));
  always_comb begin
    start = alu_ready && valid;
    ack_to = alu_ready && cnt == CW'(ACK_WAIT);
    busy_to = !alu_ready && cnt == CW'(TIMEOUT);
    state_n = state;
    case (state)
      IDLE:      state_n = start ? ISSUE : IDLE;
      ISSUE:     state_n = WAIT_BUSY;
      WAIT_BUSY: state_n = !alu_ready ? WAIT_DONE : ack_to ? RESP : WAIT_BUSY;
      WAIT_DONE: state_n = (alu_ready || busy_to) ? RESP : WAIT_DONE;
      default:   state_n = IDLE;
    endcase
    alu_cs = state == ISSUE;
    gnt0 = state != IDLE && !owner;
    gnt1 = state != IDLE && owner;
    done0 = state == RESP && !owner;
    done1 = state == RESP && owner;
    err = state == RESP && err_q;
  end
  // Only the falling edge of alu_ready matters in WAIT_BUSY; a high level just keeps the watchdog running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      owner <= 1'b0;
      last <= 1'b1;
      err_q <= 1'b0;
      alu_mode <= 1'b0;
      alu_a <= '0;
      alu_b <= '0;
      result <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (start) begin
          owner <= pick;
          alu_a <= pick ? a1 : a0;
          alu_b <= pick ? b1 : b0;
          alu_mode <= pick ? mode1 : mode0;
        end
        ISSUE: begin
          cnt <= '0;
          err_q <= 1'b0;
        end
        WAIT_BUSY: begin
          cnt <= alu_ready ? cnt + 1'b1 : '0;
          err_q <= ack_to;
        end
        WAIT_DONE: begin
          cnt <= cnt + 1'b1;
          result <= alu_ready ? alu_bus : busy_to ? '0 : result;
          err_q <= busy_to;
        end
        RESP: last <= owner;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized two-requester traffic against a behavioural ALU, checked by a scoreboard
module tb_alu_arbiter;
  import alu_ctrl_pkg::*;
  localparam int W = 16, A = 4, T = 20;
  logic clk = 1'b0, rst_n = 1'b0;
  logic rq [2];
  logic rm [2];
  logic [W-1:0] ra [2], rb [2];
  logic gnt0, gnt1, done0, done1, err, alu_cs, alu_mode, alu_ready;
  logic [W-1:0] result, alu_a, alu_b, alu_bus;
  int cyc = 0, errors = 0, checks = 0, ndone = 0;
  int scen_kind, scen_d, scen_k;
  logic s_rq [2];
  logic s_rm [2];
  logic [W-1:0] s_ra [2], s_rb [2];
  typedef struct {logic win; logic [W-1:0] res; logic err; logic chk_res; int lat;} exp_t;
  exp_t exp_q[$];

  alu_arbiter #(.WIDTH(W), .ACK_WAIT(A), .TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .req0(rq[0]), .req1(rq[1]),
    .a0(ra[0]), .b0(rb[0]), .a1(ra[1]), .b1(rb[1]), .mode0(rm[0]), .mode1(rm[1]),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err), .result(result),
    .alu_cs(alu_cs), .alu_mode(alu_mode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_bus(alu_bus), .alu_ready(alu_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      s_rq[i] <= rq[i];
      s_ra[i] <= ra[i];
      s_rb[i] <= rb[i];
      s_rm[i] <= rm[i];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural ALU: kind 0 = normal (ready high d cycles after cs, then busy k cycles),
  // kind 1 = never acknowledges, kind 2 = acknowledges but never finishes
  initial begin
    int kind, d, k, r;
    alu_ready = 1'b1;
    alu_bus = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || !alu_cs) continue;
      kind = scen_kind; d = scen_d; k = scen_k;
      if (kind != 1) begin
        repeat (d + 1) @(posedge clk);
        #1 alu_ready = 1'b0;
        alu_bus = W'($urandom);
      end
      if (kind == 0) begin
        repeat (k) @(posedge clk);
        #1 alu_ready = 1'b1;
        alu_bus = (alu_mode == ALU_SUB) ? alu_a - alu_b : alu_a + alu_b;
      end
      do @(negedge clk); while (!(done0 || done1) && rst_n);
      if (kind == 2) begin
        repeat (2) @(posedge clk);
        #1 alu_ready = 1'b1;
      end
      r = $urandom_range(0, 9);
      scen_kind = r == 0 ? 1 : r == 1 ? 2 : 0;
      scen_d = $urandom_range(1, A);
      scen_k = $urandom_range(1, 6);
    end
  end

  // Monitor/scoreboard: reference arbitration is "the requester not served last wins a tie"
  initial begin
    logic prev_g, active, cur_own, model_last, w;
    logic [W-1:0] opa, opb;
    int cs_cnt, g_cyc;
    exp_t e;
    prev_g = 0; active = 0; cur_own = 0; model_last = 1; cs_cnt = 0; g_cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        active = 0; prev_g = 0; model_last = 1;
        continue;
      end
      if (gnt0 || gnt1) check("gnt_onehot", gnt0 & gnt1, 0);
      if ((gnt0 || gnt1) && !prev_g) begin
        w = (s_rq[0] && s_rq[1]) ? !model_last : s_rq[1];
        check("winner", gnt1, w);
        check("cs_at_issue", alu_cs, 1);
        opa = s_ra[w]; opb = s_rb[w];
        e.win = w;
        e.res = (s_rm[w] == ALU_SUB) ? opa - opb : opa + opb;
        e.err = scen_kind != 0;
        e.chk_res = scen_kind != 1;
        if (scen_kind == 2) e.res = '0;
        e.lat = scen_kind == 0 ? 3 + scen_d + scen_k : scen_kind == 1 ? 3 + A : 4 + scen_d + T;
        exp_q.push_back(e);
        active = 1; cur_own = w; cs_cnt = 0; g_cyc = cyc;
      end else if (active) check("gnt_hold", cur_own ? gnt1 : gnt0, 1);
      if (alu_cs) cs_cnt++;
      if (done0 || done1) begin
        check("done_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("done_owner", {done1, done0}, e.win ? 2 : 1);
          check("err", err, e.err);
          if (e.chk_res) check("result", result, e.res);
          check("latency", cyc - g_cyc + 1, e.lat);
          check("cs_pulses", cs_cnt, 1);
          model_last = e.win;
        end
        active = 0;
        ndone++;
      end
      prev_g = gnt0 || gnt1;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic dn [2];
    logic gg [2];
    int n, base;
    for (int i = 0; i < 2; i++) begin
      rq[i] = 0; ra[i] = '0; rb[i] = '0; rm[i] = 0;
    end
    scen_kind = 0; scen_d = 1; scen_k = 2;
    repeat (3) @(posedge clk);
    #1 check("reset_ctrl_idle", {gnt0, gnt1, done0, done1, err, alu_cs, alu_mode}, 0);
    check("reset_data_idle", alu_a | alu_b | result, 0);
    rq[0] = 1; ra[0] = 16'h0003; rb[0] = 16'h0004; rm[0] = ALU_ADD;
    @(negedge clk);
    rst_n = 1;
    while (ndone < 40 && cyc < 20000) begin
      @(negedge clk);
      dn[0] = done0; dn[1] = done1; gg[0] = gnt0; gg[1] = gnt1;
      @(posedge clk);
      #2;
      for (int i = 0; i < 2; i++) begin
        if (rq[i]) begin
          if (dn[i] && $urandom_range(0, 1) == 0) rq[i] = 0;
          else if (dn[i] || gg[i]) begin
            ra[i] = W'($urandom); rb[i] = W'($urandom); rm[i] = 1'($urandom);
          end
        end else if ($urandom_range(0, 3) == 0) begin
          rq[i] = 1; ra[i] = W'($urandom); rb[i] = W'($urandom); rm[i] = 1'($urandom);
        end
      end
    end
    check("random_progress", ndone >= 40, 1);
    rq[0] = 0; rq[1] = 0;
    n = 0;
    while ((exp_q.size() != 0 || gnt0 || gnt1 || !alu_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_random", n < 500, 1);
    scen_kind = 2; scen_d = 1;
    @(posedge clk);
    #2 rq[0] = 1; ra[0] = 16'h0003; rb[0] = 16'h0004; rm[0] = ALU_ADD;
    n = 0;
    while (!gnt0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reset_test_grant", gnt0, 1);
    repeat (5) @(posedge clk);
    #3 rst_n = 0;
    #1 check("abort_ctrl_zero", {gnt0, gnt1, done0, done1, err, alu_cs, alu_mode}, 0);
    check("abort_data_zero", alu_a | alu_b | result, 0);
    rq[1] = 1; ra[1] = 16'h0010; rb[1] = 16'h0001; rm[1] = ALU_SUB;
    repeat (3) begin
      @(negedge clk);
      check("no_done_in_reset", done0 | done1, 0);
    end
    rst_n = 1;
    base = ndone;
    n = 0;
    while (!(gnt0 || gnt1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("tie_after_reset_gnt0", gnt0, 1);
    n = 0;
    while (ndone < base + 4 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("tie_alternation_done", ndone >= base + 4, 1);
    rq[0] = 0; rq[1] = 0;
    n = 0;
    while ((exp_q.size() != 0 || gnt0 || gnt1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_final", n < 200, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
